exec_stage_iter: RTL and testbench
==================================

# exec_stage_iter

Parametrised execution stage of the pipelined processor, sitting between the decode and memory stages. It performs single-cycle ALU operations on `WIDTH`-bit operands and registers the result, flags and memory/write-back sideband into the EX/MEM pipeline register. It also performs multi-cycle iterative multiply, and optionally divide, stalling decode through a handshake while the iteration runs.

## Interface
- `WIDTH`, 8: operand/result width, ≥4.
- `RW_W`, 5: destination register address width.
- `clk` input 1: clock; all state updates on rising edge.
- `reset` input 1: synchronous, active-high.
- `valid_dec` input 1: decode presents a valid op this cycle.
- `A`, `B` input `WIDTH`: operands.
- `data_in` input `WIDTH`: store data, passed to `data_out`.
- `op_dec` input 5: opcode.
- `mem_en_dec`, `mem_rw_dec`, `mem_mux_sel_dec` input 1 each: memory sideband.
- `RW_dec` input `RW_W`: destination register.
- `stall_ex` output 1: decode must hold all inputs while high.
- `valid_ex` output 1: EX/MEM register holds a real op.
- `ans_ex` output `WIDTH`: result.
- `flag_ex` output 4: {V, N, C, Z} = bits [3:0] as [3]=V, [2]=N, [1]=C, [0]=Z.
- `data_out`, `B_Bypass` output `WIDTH`: registered `data_in` and `B`.
- `mem_en_ex`, `mem_rw_ex`, `mem_mux_sel_ex` output 1; `RW_ex` output `RW_W`: registered sideband.

## Operation
- Opcodes:
  - 00000 ADD
  - 00001 ADC (uses stored C)
  - 00010 SUB (A−B, C = no-borrow)
  - 00011 SBB
  - 00100 AND
  - 00101 OR
  - 00110 XOR
  - 00111 NOT A
  - 01000 SHL A
  - 01001 SHR A (logical)
  - 01010 ROL A
  - 01011 ROR A
  - 01100 MOV B
  - 01101 CMP (flags from A−B; `ans_ex` holds)
  - 01110 MULL (low `WIDTH` bits of A·B, unsigned)
  - 01111 MULH (high `WIDTH` bits)
  - 10000 DIVQ, 10001 DIVR (unsigned; only with divider enabled)
  - all others: NOP (`valid_ex`=1, `ans_ex` and flags hold).
- Flags:
  - Z = result==0.
  - N = result MSB.
  - C = carry out of add/sub, or the bit shifted out for shifts/rotates.
  - V = signed overflow for add/sub, cleared otherwise.
  - Logic/MOV ops clear C and V.
  - MUL: C = V = (high half ≠ 0).
- FSM states IDLE and BUSY. A multi-cycle op (MULL/MULH/DIVQ/DIVR) with `valid_dec` in IDLE:
  - latches operands and loads count `WIDTH-1`;
  - moves to BUSY;
  - runs one shift-add (or restoring-subtract) step per cycle;
  - on the count==0 step, writes the result, flags and sideband, and returns to IDLE.
- `stall_ex` = (IDLE & `valid_dec` & multi-cycle op) | (BUSY & count≠0). It is forced to 0 while `reset` is high.
- While `stall_ex` is high, EX/MEM takes a bubble:
  - `valid_ex`=0 and `mem_en_ex`=0;
  - other outputs hold.
- Divide by zero: quotient all-ones, remainder = A, V=1.
- Every non-stalled cycle with `valid_dec`=0 loads a bubble (`valid_ex`=0, `mem_en_ex`=0).

## Timing
- Reset (edge with `reset`=1) clears all outputs to 0, state to IDLE, count to 0 and stored C to 0; reset mid-iteration abandons the op.
- Single-cycle ops: inputs sampled at edge N, outputs valid after edge N; `stall_ex` stays 0.
- Multi-cycle ops:
  - inputs must be presented for `WIDTH`+1 cycles;
  - `stall_ex` is high for the first `WIDTH` of them;
  - the result appears after edge `WIDTH`+1 counted from the first presentation.
- Decode's next op is sampled on the edge after `stall_ex` falls.
- The operand latch ignores input changes during BUSY.
- `B_Bypass` and `data_out` follow the sideband: they update only on non-stalled edges.

## Configuration
- `EXEC_DIV_EN`:
  - Defined: restoring divider instantiated; DIVQ/DIVR use the same IDLE/BUSY handshake and latency as MUL.
  - Undefined: no divider logic; opcodes 10000/10001 execute as NOP with no stall.

## Test plan
- Reset, then ADD A=0x40, B=0xC0 (`WIDTH`=8) -> `ans_ex`=0x00, flags Z=1, C=1, V=0, N=0 after one edge; `stall_ex`=0.
- SUB A=0x80, B=0x01 -> `ans_ex`=0x7F, V=1, C=1; then ADC A=0x01, B=0x01 with stored C=1 -> 0x03.
- MULH A=0xC0, B=0x04 with `RW_dec`=0x0A and `mem_en_dec`=1 held:
  - `stall_ex` high exactly 8 cycles, `valid_ex`=0 meanwhile;
  - then `ans_ex`=0x03, C=V=1, `RW_ex`=0x0A, `mem_en_ex`=1.
- MULL in progress, `reset` pulsed at the 4th BUSY cycle -> all outputs 0, IDLE, `stall_ex`=0 that cycle; the next ADD completes normally in one cycle.
- With `EXEC_DIV_EN`:
  - DIVQ 0xC8/0x07 -> 0x1C;
  - DIVR -> 0x04;
  - DIVQ by 0 -> 0xFF with V=1.
- Without `EXEC_DIV_EN`, op 10000 -> no stall, `ans_ex` unchanged.

Source files
------------

// File: rtl/exec_stage_iter.sv
// exec_stage_iter: pipelined execution stage. Performs single-cycle ALU ops
// and multi-cycle iterative multiply (and divide, when EXEC_DIV_EN is defined)
// and registers the result, flags and memory/write-back sideband into EX/MEM.
//
// Optional feature macro: EXEC_DIV_EN (restoring divider, opcodes DIVQ/DIVR).
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   valid_dec                   decode presents a valid op
//   A, B, data_in               operands and store data
//   op_dec                      5-bit opcode
//   mem_en/rw/mux_sel_dec, RW_dec  memory / write-back sideband in
//   stall_ex                    combinational; decode holds inputs while high
//   valid_ex, ans_ex, flag_ex   registered result, flags {V,N,C,Z}
//   data_out, B_Bypass          registered data_in and B
//   mem_en/rw/mux_sel_ex, RW_ex registered sideband
module exec_stage_iter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned RW_W  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_dec,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] data_in,
  input  logic [4:0]       op_dec,
  input  logic             mem_en_dec,
  input  logic             mem_rw_dec,
  input  logic             mem_mux_sel_dec,
  input  logic [RW_W-1:0]  RW_dec,
  output logic             stall_ex,
  output logic             valid_ex,
  output logic [WIDTH-1:0] ans_ex,
  output logic [3:0]       flag_ex,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] B_Bypass,
  output logic             mem_en_ex,
  output logic             mem_rw_ex,
  output logic             mem_mux_sel_ex,
  output logic [RW_W-1:0]  RW_ex
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam int unsigned MSB   = WIDTH - 1;

  localparam logic [4:0] OP_ADD  = 5'h00, OP_ADC = 5'h01, OP_SUB = 5'h02, OP_SBB = 5'h03;
  localparam logic [4:0] OP_AND  = 5'h04, OP_OR  = 5'h05, OP_XOR = 5'h06, OP_NOT = 5'h07;
  localparam logic [4:0] OP_SHL  = 5'h08, OP_SHR = 5'h09, OP_ROL = 5'h0A, OP_ROR = 5'h0B;
  localparam logic [4:0] OP_MOV  = 5'h0C, OP_CMP = 5'h0D, OP_MULL = 5'h0E, OP_MULH = 5'h0F;
`ifdef EXEC_DIV_EN
  localparam logic [4:0] OP_DIVQ = 5'h10, OP_DIVR = 5'h11;
`endif

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] m_q, m_d, hi_q, hi_d, lo_q, lo_d;
  logic             sel_hi_q, sel_hi_d;
`ifdef EXEC_DIV_EN
  logic             is_div_q, is_div_d;
  logic [WIDTH:0]   rem_sh;
`endif

  logic             valid_q, valid_d, men_q, men_d, mrw_q, mrw_d, msel_q, msel_d;
  logic [WIDTH-1:0] ans_q, ans_d, dout_q, dout_d, bby_q, bby_d;
  logic [3:0]       flag_q, flag_d;
  logic [RW_W-1:0]  rw_q, rw_d;

  logic             multi_op, load_sb;
  logic [WIDTH-1:0] b_op, alu_val, step_hi, step_lo, it_res;
  logic [WIDTH:0]   sum, mul_sum;
  logic             cin, alu_c, alu_v, alu_wr_ans, alu_wr_flg;
  logic [3:0]       alu_flags, it_flags;

  assign valid_ex       = valid_q;
  assign ans_ex         = ans_q;
  assign flag_ex        = flag_q;
  assign data_out       = dout_q;
  assign B_Bypass       = bby_q;
  assign mem_en_ex      = men_q;
  assign mem_rw_ex      = mrw_q;
  assign mem_mux_sel_ex = msel_q;
  assign RW_ex          = rw_q;

  // Opcodes handled by the iterative datapath
  always_comb begin
    multi_op = (op_dec == OP_MULL) || (op_dec == OP_MULH);
`ifdef EXEC_DIV_EN
    multi_op = multi_op || (op_dec == OP_DIVQ) || (op_dec == OP_DIVR);
`endif
  end

  // Single-cycle ALU; subtract forms are A + ~B + cin so C is no-borrow
  always_comb begin
    b_op       = (op_dec == OP_SUB || op_dec == OP_SBB || op_dec == OP_CMP) ? ~B : B;
    cin        = (op_dec == OP_SUB || op_dec == OP_CMP) ||
                 ((op_dec == OP_ADC || op_dec == OP_SBB) && flag_q[1]);
    sum        = {1'b0, A} + {1'b0, b_op} + (WIDTH+1)'(cin);
    alu_val    = sum[WIDTH-1:0];
    alu_c      = 1'b0;
    alu_v      = 1'b0;
    alu_wr_ans = 1'b1;
    alu_wr_flg = 1'b1;
    case (op_dec)
      OP_ADD, OP_ADC, OP_SUB, OP_SBB, OP_CMP: begin
        alu_c      = sum[WIDTH];
        alu_v      = (A[MSB] == b_op[MSB]) && (sum[MSB] != A[MSB]);
        alu_wr_ans = (op_dec != OP_CMP);
      end
      OP_AND: alu_val = A & B;
      OP_OR:  alu_val = A | B;
      OP_XOR: alu_val = A ^ B;
      OP_NOT: alu_val = ~A;
      OP_SHL: begin alu_val = {A[MSB-1:0], 1'b0};   alu_c = A[MSB]; end
      OP_SHR: begin alu_val = {1'b0, A[MSB:1]};     alu_c = A[0];   end
      OP_ROL: begin alu_val = {A[MSB-1:0], A[MSB]}; alu_c = A[MSB]; end
      OP_ROR: begin alu_val = {A[0], A[MSB:1]};     alu_c = A[0];   end
      OP_MOV: alu_val = B;
      default: begin
        alu_wr_ans = 1'b0;
        alu_wr_flg = 1'b0;
      end
    endcase
    alu_flags = {alu_v, alu_val[MSB], alu_c, alu_val == '0};
  end

  // One iteration step: shift-add multiply on {hi,lo}, or restoring divide
  // with hi as partial remainder and lo shifting dividend out / quotient in
  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
    step_hi = mul_sum[WIDTH:1];
    step_lo = {mul_sum[0], lo_q[MSB:1]};
`ifdef EXEC_DIV_EN
    rem_sh = {hi_q, lo_q[MSB]};
    if (is_div_q) begin
      if (rem_sh >= {1'b0, m_q}) begin
        step_hi = rem_sh[WIDTH-1:0] - m_q;
        step_lo = {lo_q[MSB-1:0], 1'b1};
      end else begin
        step_hi = rem_sh[WIDTH-1:0];
        step_lo = {lo_q[MSB-1:0], 1'b0};
      end
    end
`endif
    it_res   = sel_hi_q ? step_hi : step_lo;
    it_flags = {step_hi != '0, it_res[MSB], step_hi != '0, it_res == '0};
`ifdef EXEC_DIV_EN
    if (is_div_q) it_flags = {m_q == '0, it_res[MSB], 1'b0, it_res == '0};
`endif
  end

  // Next-state and EX/MEM register inputs
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    m_d      = m_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    sel_hi_d = sel_hi_q;
`ifdef EXEC_DIV_EN
    is_div_d = is_div_q;
`endif
    ans_d    = ans_q;
    flag_d   = flag_q;
    load_sb  = 1'b0;
    stall_ex = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (valid_dec && multi_op) begin
          stall_ex = 1'b1;
          state_d  = S_BUSY;
          cnt_d    = CNT_W'(WIDTH - 1);
          m_d      = A;
          lo_d     = B;
          hi_d     = '0;
          sel_hi_d = op_dec[0];
`ifdef EXEC_DIV_EN
          is_div_d = op_dec[4];
          if (op_dec[4]) begin
            m_d  = B;
            lo_d = A;
          end
`endif
        end else if (valid_dec) begin
          load_sb = 1'b1;
          if (alu_wr_ans) ans_d  = alu_val;
          if (alu_wr_flg) flag_d = alu_flags;
        end
      end
      S_BUSY: begin
        hi_d = step_hi;
        lo_d = step_lo;
        if (cnt_q != '0) begin
          stall_ex = 1'b1;
          cnt_d    = cnt_q - CNT_W'(1);
        end else begin
          state_d = S_IDLE;
          load_sb = 1'b1;
          ans_d   = it_res;
          flag_d  = it_flags;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Every edge either completes an op or inserts a bubble
    valid_d = load_sb;
    men_d   = load_sb & mem_en_dec;
    mrw_d   = load_sb ? mem_rw_dec      : mrw_q;
    msel_d  = load_sb ? mem_mux_sel_dec : msel_q;
    rw_d    = load_sb ? RW_dec          : rw_q;
    dout_d  = load_sb ? data_in         : dout_q;
    bby_d   = load_sb ? B               : bby_q;
    if (reset) stall_ex = 1'b0;
  end

  // State and EX/MEM registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      m_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      sel_hi_q <= 1'b0;
`ifdef EXEC_DIV_EN
      is_div_q <= 1'b0;
`endif
      valid_q  <= 1'b0;
      ans_q    <= '0;
      flag_q   <= '0;
      dout_q   <= '0;
      bby_q    <= '0;
      men_q    <= 1'b0;
      mrw_q    <= 1'b0;
      msel_q   <= 1'b0;
      rw_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      m_q      <= m_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      sel_hi_q <= sel_hi_d;
`ifdef EXEC_DIV_EN
      is_div_q <= is_div_d;
`endif
      valid_q  <= valid_d;
      ans_q    <= ans_d;
      flag_q   <= flag_d;
      dout_q   <= dout_d;
      bby_q    <= bby_d;
      men_q    <= men_d;
      mrw_q    <= mrw_d;
      msel_q   <= msel_d;
      rw_q     <= rw_d;
    end
  end

endmodule

// File: tb/tb_exec_stage_iter.sv
// Testbench for exec_stage_iter: directed ops checked every cycle against a
// transaction-level arithmetic model, plus literal expectations.
module tb_exec_stage_iter;

  localparam int W    = 8;
  localparam int RWW  = 5;
  localparam int MASK = (1 << W) - 1;
  localparam int HALF = 1 << (W - 1);

  logic           clk = 1'b0;
  logic           reset;
  logic           valid_dec;
  logic [W-1:0]   A, B, data_in;
  logic [4:0]     op_dec;
  logic           mem_en_dec, mem_rw_dec, mem_mux_sel_dec;
  logic [RWW-1:0] RW_dec;
  logic           stall_ex, valid_ex, mem_en_ex, mem_rw_ex, mem_mux_sel_ex;
  logic [W-1:0]   ans_ex, data_out, B_Bypass;
  logic [3:0]     flag_ex;
  logic [RWW-1:0] RW_ex;

  // expected DUT outputs
  logic           e_stall, e_valid, e_men, e_mrw, e_msel;
  logic [W-1:0]   e_ans, e_dout, e_bby;
  logic [3:0]     e_flag;
  logic [RWW-1:0] e_rw;

  int   n_checks   = 0;
  int   n_err      = 0;
  int   stall_seen = 0;
  logic chk_en     = 1'b0;

  exec_stage_iter #(.WIDTH(W), .RW_W(RWW)) dut (
    .clk(clk), .reset(reset), .valid_dec(valid_dec), .A(A), .B(B),
    .data_in(data_in), .op_dec(op_dec), .mem_en_dec(mem_en_dec),
    .mem_rw_dec(mem_rw_dec), .mem_mux_sel_dec(mem_mux_sel_dec), .RW_dec(RW_dec),
    .stall_ex(stall_ex), .valid_ex(valid_ex), .ans_ex(ans_ex), .flag_ex(flag_ex),
    .data_out(data_out), .B_Bypass(B_Bypass), .mem_en_ex(mem_en_ex),
    .mem_rw_ex(mem_rw_ex), .mem_mux_sel_ex(mem_mux_sel_ex), .RW_ex(RW_ex)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("stall_ex",       32'(stall_ex),       32'(e_stall));
      check("valid_ex",       32'(valid_ex),       32'(e_valid));
      check("ans_ex",         32'(ans_ex),         32'(e_ans));
      check("flag_ex",        32'(flag_ex),        32'(e_flag));
      check("data_out",       32'(data_out),       32'(e_dout));
      check("B_Bypass",       32'(B_Bypass),       32'(e_bby));
      check("mem_en_ex",      32'(mem_en_ex),      32'(e_men));
      check("mem_rw_ex",      32'(mem_rw_ex),      32'(e_mrw));
      check("mem_mux_sel_ex", 32'(mem_mux_sel_ex), 32'(e_msel));
      check("RW_ex",          32'(RW_ex),          32'(e_rw));
    end
  end

  task automatic cyc();
    @(negedge clk);
    if (stall_ex === 1'b1) stall_seen++;
    @(posedge clk);
    #1;
  endtask

  function automatic int sgn(input int x);
    return (x >= HALF) ? x - 2 * HALF : x;
  endfunction

  function automatic logic ovf(input int s);
    return (s > HALF - 1) || (s < -HALF);
  endfunction

  function automatic logic is_multi(input logic [4:0] op);
    logic r;
    r = (op == 5'h0E) || (op == 5'h0F);
`ifdef EXEC_DIV_EN
    r = r || (op == 5'h10) || (op == 5'h11);
`endif
    return r;
  endfunction

  // single-cycle op semantics in plain integer arithmetic
  task automatic model_alu(input logic [4:0] op, input int a, input int b, input int cst,
                           output logic wa, output logic wf, output int r,
                           output logic c, output logic v);
    int bor;
    wa = 1'b1; wf = 1'b1; c = 1'b0; v = 1'b0; r = 0; bor = 1 - cst;
    case (op)
      5'h00: begin r = a + b;       c = (r > MASK);    v = ovf(sgn(a) + sgn(b)); end
      5'h01: begin r = a + b + cst; c = (r > MASK);    v = ovf(sgn(a) + sgn(b) + cst); end
      5'h02: begin r = a - b;       c = (a >= b);      v = ovf(sgn(a) - sgn(b)); end
      5'h03: begin r = a - b - bor; c = (a >= b + bor); v = ovf(sgn(a) - sgn(b) - bor); end
      5'h04: r = a & b;
      5'h05: r = a | b;
      5'h06: r = a ^ b;
      5'h07: r = MASK - a;
      5'h08: begin r = a * 2; c = (a >= HALF); end
      5'h09: begin r = a / 2; c = ((a % 2) != 0); end
      5'h0A: begin r = (a * 2) % (MASK + 1) + ((a >= HALF) ? 1 : 0); c = (a >= HALF); end
      5'h0B: begin r = a / 2 + (a % 2) * HALF; c = ((a % 2) != 0); end
      5'h0C: r = b;
      5'h0D: begin r = a - b; c = (a >= b); v = ovf(sgn(a) - sgn(b)); wa = 1'b0; end
      default: begin wa = 1'b0; wf = 1'b0; end
    endcase
    r = r & MASK;
  endtask

  // model update for a completed valid op
  task automatic finish_op(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] din, input logic men, input logic mrw,
                           input logic msel, input logic [RWW-1:0] rw);
    logic wa, wf, c, v;
    int   r, prod, hi, q, rm;
    e_valid = 1'b1; e_dout = din; e_bby = b; e_men = men; e_mrw = mrw; e_msel = msel; e_rw = rw;
    if (is_multi(op)) begin
      if (op == 5'h10 || op == 5'h11) begin
        if (b == 0) begin q = MASK; rm = int'(a); v = 1'b1; end
        else begin q = int'(a) / int'(b); rm = int'(a) % int'(b); v = 1'b0; end
        r = (op == 5'h11) ? rm : q;
        c = 1'b0;
      end else begin
        prod = int'(a) * int'(b);
        hi   = prod / (MASK + 1);
        r    = (op == 5'h0F) ? hi : (prod & MASK);
        c    = (hi != 0);
        v    = c;
      end
      e_ans  = W'(r);
      e_flag = {v, r >= HALF, c, r == 0};
    end else begin
      model_alu(op, int'(a), int'(b), int'(e_flag[1]), wa, wf, r, c, v);
      if (wa) e_ans = W'(r);
      if (wf) e_flag = {v, r >= HALF, c, r == 0};
    end
  endtask

  // present one op for as many cycles as the handshake requires
  task automatic issue(input logic vld, input logic [4:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] din, input logic men,
                       input logic mrw, input logic msel, input logic [RWW-1:0] rw,
                       input logic scramble);
    valid_dec = vld; op_dec = op; A = a; B = b; data_in = din;
    mem_en_dec = men; mem_rw_dec = mrw; mem_mux_sel_dec = msel; RW_dec = rw;
    if (vld && is_multi(op)) begin
      for (int i = 0; i < W; i++) begin
        if (scramble && i > 0) begin A = ~a; B = ~b; end
        e_stall = 1'b1;
        cyc();
        e_valid = 1'b0; e_men = 1'b0;
      end
      A = a; B = b;
    end
    e_stall = 1'b0;
    cyc();
    if (vld) finish_op(op, a, b, din, men, mrw, msel, rw);
    else begin e_valid = 1'b0; e_men = 1'b0; end
  endtask

  task automatic clear_model();
    e_stall = 1'b0; e_valid = 1'b0; e_men = 1'b0; e_mrw = 1'b0; e_msel = 1'b0;
    e_ans = '0; e_dout = '0; e_bby = '0; e_flag = '0; e_rw = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1; valid_dec = 1'b0; e_stall = 1'b0;
    cyc();
    clear_model();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; valid_dec = 1'b0; op_dec = '0; A = '0; B = '0; data_in = '0;
    mem_en_dec = 1'b0; mem_rw_dec = 1'b0; mem_mux_sel_dec = 1'b0; RW_dec = '0;
    clear_model();
    cyc();
    chk_en = 1'b1;
    do_reset();
    check("rst_valid", 32'(valid_ex), 32'h0);
    check("rst_ans",   32'(ans_ex),   32'h0);

    issue(1'b1, 5'h00, 8'h40, 8'hC0, 8'h11, 1'b1, 1'b0, 1'b1, 5'h01, 1'b0);
    check("lit_add_ans",   32'(ans_ex),   32'h00);
    check("lit_add_flag",  32'(flag_ex),  32'h3);
    check("lit_add_stall", 32'(stall_ex), 32'h0);
    issue(1'b1, 5'h02, 8'h80, 8'h01, 8'h22, 1'b0, 1'b1, 1'b0, 5'h02, 1'b0);
    check("lit_sub_ans",  32'(ans_ex),  32'h7F);
    check("lit_sub_flag", 32'(flag_ex), 32'hA);
    issue(1'b1, 5'h01, 8'h01, 8'h01, 8'h33, 1'b1, 1'b1, 1'b1, 5'h03, 1'b0);
    check("lit_adc_ans", 32'(ans_ex), 32'h03);
    issue(1'b0, 5'h00, 8'h12, 8'h34, 8'h44, 1'b1, 1'b0, 1'b0, 5'h04, 1'b0);

    issue(1'b1, 5'h00, 8'h7F, 8'h01, 8'h01, 1'b1, 1'b0, 1'b0, 5'h05, 1'b0);
    issue(1'b1, 5'h02, 8'h05, 8'h07, 8'h02, 1'b0, 1'b1, 1'b0, 5'h06, 1'b0);
    issue(1'b1, 5'h03, 8'h10, 8'h01, 8'h03, 1'b1, 1'b0, 1'b1, 5'h07, 1'b0);
    issue(1'b1, 5'h01, 8'h10, 8'h01, 8'h04, 1'b0, 1'b0, 1'b1, 5'h08, 1'b0);
    issue(1'b1, 5'h04, 8'hF0, 8'h3C, 8'h05, 1'b1, 1'b1, 1'b0, 5'h09, 1'b0);
    issue(1'b1, 5'h05, 8'hF0, 8'h0C, 8'h06, 1'b0, 1'b0, 1'b0, 5'h0B, 1'b0);
    issue(1'b1, 5'h06, 8'hAA, 8'hFF, 8'h07, 1'b1, 1'b0, 1'b1, 5'h0C, 1'b0);
    issue(1'b1, 5'h07, 8'h5A, 8'h00, 8'h08, 1'b0, 1'b1, 1'b1, 5'h0D, 1'b0);
    issue(1'b1, 5'h08, 8'h81, 8'h00, 8'h09, 1'b1, 1'b0, 1'b0, 5'h0E, 1'b0);
    issue(1'b1, 5'h09, 8'h81, 8'h00, 8'h0A, 1'b0, 1'b0, 1'b1, 5'h0F, 1'b0);
    issue(1'b1, 5'h0A, 8'h81, 8'h00, 8'h0B, 1'b1, 1'b1, 1'b0, 5'h10, 1'b0);
    issue(1'b1, 5'h0B, 8'h01, 8'h00, 8'h0C, 1'b0, 1'b1, 1'b0, 5'h11, 1'b0);
    issue(1'b1, 5'h0C, 8'h77, 8'h00, 8'h0D, 1'b1, 1'b0, 1'b1, 5'h12, 1'b0);
    issue(1'b1, 5'h0D, 8'h33, 8'h33, 8'h0E, 1'b0, 1'b0, 1'b0, 5'h13, 1'b0);
    check("lit_cmp_ans", 32'(ans_ex), 32'h00);
    issue(1'b1, 5'h1F, 8'h01, 8'h02, 8'h0F, 1'b1, 1'b1, 1'b1, 5'h14, 1'b0);
    issue(1'b1, 5'h00, 8'hFF, 8'h01, 8'h10, 1'b1, 1'b0, 1'b0, 5'h15, 1'b0);

    stall_seen = 0;
    issue(1'b1, 5'h0F, 8'hC0, 8'h04, 8'h99, 1'b1, 1'b1, 1'b0, 5'h0A, 1'b1);
    check("lit_mulh_stall_cycles", 32'(stall_seen), 32'd8);
    check("lit_mulh_ans",  32'(ans_ex),    32'h03);
    check("lit_mulh_flag", 32'(flag_ex),   32'hA);
    check("lit_mulh_rw",   32'(RW_ex),     32'h0A);
    check("lit_mulh_men",  32'(mem_en_ex), 32'h1);
    issue(1'b1, 5'h00, 8'h21, 8'h43, 8'h55, 1'b0, 1'b0, 1'b1, 5'h16, 1'b0);
    issue(1'b1, 5'h0E, 8'h0F, 8'h11, 8'h66, 1'b1, 1'b0, 1'b1, 5'h17, 1'b0);
    issue(1'b1, 5'h0E, 8'hFF, 8'hFF, 8'h67, 1'b0, 1'b1, 1'b1, 5'h18, 1'b0);
    check("lit_mull_ff_ans", 32'(ans_ex), 32'h01);

    // reset during the 4th BUSY cycle of a MULL
    valid_dec = 1'b1; op_dec = 5'h0E; A = 8'h0D; B = 8'h0B; mem_en_dec = 1'b1;
    e_stall = 1'b1;
    cyc();
    e_valid = 1'b0; e_men = 1'b0;
    repeat (3) cyc();
    reset = 1'b1; e_stall = 1'b0;
    #1;
    check("lit_rst_mid_stall", 32'(stall_ex), 32'h0);
    cyc();
    clear_model();
    reset = 1'b0;
    check("lit_rst_mid_ans", 32'(ans_ex), 32'h0);
    check("lit_rst_mid_rw",  32'(RW_ex),  32'h0);
    issue(1'b1, 5'h00, 8'h12, 8'h34, 8'h5A, 1'b1, 1'b0, 1'b0, 5'h19, 1'b0);
    check("lit_post_rst_add", 32'(ans_ex), 32'h46);

`ifdef EXEC_DIV_EN
    issue(1'b1, 5'h10, 8'hC8, 8'h07, 8'h70, 1'b1, 1'b0, 1'b0, 5'h1A, 1'b1);
    check("lit_divq_ans", 32'(ans_ex), 32'h1C);
    issue(1'b1, 5'h11, 8'hC8, 8'h07, 8'h71, 1'b0, 1'b1, 1'b0, 5'h1B, 1'b0);
    check("lit_divr_ans", 32'(ans_ex), 32'h04);
    issue(1'b1, 5'h10, 8'hC8, 8'h00, 8'h72, 1'b1, 1'b1, 1'b1, 5'h1C, 1'b0);
    check("lit_div0_ans",  32'(ans_ex),  32'hFF);
    check("lit_div0_flag", 32'(flag_ex), 32'hC);
    issue(1'b1, 5'h11, 8'hC8, 8'h00, 8'h73, 1'b0, 1'b0, 1'b1, 5'h1D, 1'b0);
    issue(1'b1, 5'h10, 8'hFF, 8'h01, 8'h74, 1'b1, 1'b0, 1'b1, 5'h1E, 1'b0);
`else
    issue(1'b1, 5'h0C, 8'h00, 8'h5A, 8'h70, 1'b1, 1'b0, 1'b0, 5'h1A, 1'b0);
    stall_seen = 0;
    issue(1'b1, 5'h10, 8'h01, 8'h02, 8'h71, 1'b1, 1'b1, 1'b0, 5'h1B, 1'b0);
    check("lit_nodiv_ans",   32'(ans_ex),     32'h5A);
    check("lit_nodiv_stall", 32'(stall_seen), 32'h0);
    check("lit_nodiv_valid", 32'(valid_ex),   32'h1);
`endif

    issue(1'b0, 5'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 5'h00, 1'b0);
    issue(1'b0, 5'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 5'h00, 1'b0);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
